fb_swap_scheduler: RTL and testbench

//  Frame-buffer ownership scheduler between the MJPEG decoder (writer) and the video output DMA (reader).

---
 rtl/fb_swap_scheduler.sv | 179 +++++++++++++++++
 tb/tb_fb_swap_scheduler.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_swap_scheduler.sv
// Frame-buffer ownership scheduler between an MJPEG decoder (writer) and a
// video output DMA (reader). Each buffer carries a 2-bit ownership state.
// The writer gets the lowest-index FREE buffer. The newest completed frame
// is handed to the reader at vsync.
//
// state    | meaning
// ---------+------------------------------------------------------------
// W_IDLE   | no buffer owned by the writer; a request is served at once
// W_ALLOC  | request pending, every buffer busy; retried each cycle
// W_ACTIVE | writer owns the WRITING buffer until wr_done / wr_abort
module fb_swap_scheduler #(
  parameter int unsigned NUM_BUF    = 3,
  parameter logic [31:0] BUF_BASE   = 32'h0000_0000,
  parameter logic [31:0] BUF_STRIDE = 32'h0020_0000,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic             wr_req,
  output logic             wr_grant,
  output logic [31:0]      wr_addr,
  output logic [1:0]       wr_idx,
  input  logic             wr_done,
  input  logic             wr_abort,
  input  logic             vsync,
  output logic             rd_valid,
  output logic [31:0]      rd_addr,
  output logic [CNT_W-1:0] shown_cnt,
  output logic [CNT_W-1:0] repeat_cnt,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             proto_err
);

  typedef enum logic [1:0] {B_FREE, B_WRITING, B_READY, B_DISPLAY} buf_st_e;
  typedef enum logic [1:0] {W_IDLE, W_ALLOC, W_ACTIVE} wr_st_e;

  buf_st_e          buf_q [NUM_BUF];
  buf_st_e          buf_d [NUM_BUF];
  wr_st_e           w_q, w_d;
  logic             wr_grant_q, wr_grant_d;
  logic [1:0]       wr_idx_q, wr_idx_d;
  logic [31:0]      wr_addr_q, wr_addr_d;
  logic             rd_valid_q, rd_valid_d;
  logic [31:0]      rd_addr_q, rd_addr_d;
  logic [CNT_W-1:0] shown_q, shown_d;
  logic [CNT_W-1:0] repeat_q, repeat_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic             perr_q, perr_d;

  logic             free_found, ready_found;
  logic [1:0]       free_idx, ready_idx;
  logic             writing, alloc_try, do_abort, do_done, show_now;

  function automatic logic [31:0] buf_addr(input logic [1:0] idx);
    return BUF_BASE + (32'(idx) * BUF_STRIDE);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // Find the lowest FREE buffer and the (single) READY buffer.
  always_comb begin
    free_found  = 1'b0;
    free_idx    = '0;
    ready_found = 1'b0;
    ready_idx   = '0;
    for (int i = NUM_BUF - 1; i >= 0; i--) begin
      if (buf_q[i] == B_FREE) begin
        free_found = 1'b1;
        free_idx   = 2'(i);
      end
      if (buf_q[i] == B_READY) begin
        ready_found = 1'b1;
        ready_idx   = 2'(i);
      end
    end
  end

  // Next-state for writer FSM, buffer ownership, reader pointer and status.
  // vsync is judged on the pre-commit state, so a same-cycle wr_done never
  // displaces the frame being promoted to DISPLAY.
  always_comb begin
    buf_d      = buf_q;
    w_d        = w_q;
    wr_grant_d = 1'b0;
    wr_idx_d   = wr_idx_q;
    wr_addr_d  = wr_addr_q;
    rd_valid_d = rd_valid_q;
    rd_addr_d  = rd_addr_q;
    shown_d    = shown_q;
    repeat_d   = repeat_q;
    drop_d     = drop_q;
    perr_d     = perr_q;

    writing   = (w_q == W_ACTIVE);
    do_abort  = writing && wr_abort;
    do_done   = writing && wr_done && !wr_abort;
    show_now  = vsync && ready_found;
    alloc_try = ((w_q == W_IDLE) && wr_req) || (w_q == W_ALLOC);

    // The request is still high in the grant cycle; that is not a violation.
    if ((wr_done || wr_abort) && !writing) perr_d = 1'b1;
    if (wr_req && writing && !wr_grant_q)  perr_d = 1'b1;

    if (show_now) begin
      rd_valid_d = 1'b1;
      rd_addr_d  = buf_addr(ready_idx);
      shown_d    = sat_inc(shown_q);
    end else if (vsync && rd_valid_q) begin
      repeat_d = sat_inc(repeat_q);
    end

    if (do_done && ready_found && !vsync) drop_d = sat_inc(drop_q);
    if (do_abort || do_done) w_d = W_IDLE;

    if (alloc_try) begin
      if (free_found) begin
        wr_grant_d = 1'b1;
        wr_idx_d   = free_idx;
        wr_addr_d  = buf_addr(free_idx);
        w_d        = W_ACTIVE;
      end else begin
        w_d = W_ALLOC;
      end
    end

    for (int i = 0; i < NUM_BUF; i++) begin
      if (show_now && buf_q[i] == B_DISPLAY) buf_d[i] = B_FREE;
      if (show_now && buf_q[i] == B_READY)   buf_d[i] = B_DISPLAY;
      if (do_done && !vsync && buf_q[i] == B_READY) buf_d[i] = B_FREE;
      if (writing && 2'(i) == wr_idx_q) begin
        if (do_abort)     buf_d[i] = B_FREE;
        else if (do_done) buf_d[i] = B_READY;
      end
      if (alloc_try && free_found && 2'(i) == free_idx) buf_d[i] = B_WRITING;
    end
  end

  // State registers; reset frees every buffer immediately.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < NUM_BUF; i++) buf_q[i] <= B_FREE;
      w_q        <= W_IDLE;
      wr_grant_q <= 1'b0;
      wr_idx_q   <= '0;
      wr_addr_q  <= BUF_BASE;
      rd_valid_q <= 1'b0;
      rd_addr_q  <= BUF_BASE;
      shown_q    <= '0;
      repeat_q   <= '0;
      drop_q     <= '0;
      perr_q     <= 1'b0;
    end else begin
      buf_q      <= buf_d;
      w_q        <= w_d;
      wr_grant_q <= wr_grant_d;
      wr_idx_q   <= wr_idx_d;
      wr_addr_q  <= wr_addr_d;
      rd_valid_q <= rd_valid_d;
      rd_addr_q  <= rd_addr_d;
      shown_q    <= shown_d;
      repeat_q   <= repeat_d;
      drop_q     <= drop_d;
      perr_q     <= perr_d;
    end
  end

  assign wr_grant   = wr_grant_q;
  assign wr_idx     = wr_idx_q;
  assign wr_addr    = wr_addr_q;
  assign rd_valid   = rd_valid_q;
  assign rd_addr    = rd_addr_q;
  assign shown_cnt  = shown_q;
  assign repeat_cnt = repeat_q;
  assign drop_cnt   = drop_q;
  assign proto_err  = perr_q;

endmodule

// File: tb/tb_fb_swap_scheduler.sv
// Bench for fb_swap_scheduler: a 3-buffer/16-bit instance and a 2-buffer/3-bit
// instance share stimulus; each has its own ownership-role reference model.
module tb_fb_swap_scheduler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic wr_req = 1'b0, wr_done = 1'b0, wr_abort = 1'b0, vsync = 1'b0;

  logic g3, v3, p3, g2, v2, p2;
  logic [31:0] a3, ra3, a2, ra2;
  logic [1:0] i3, i2;
  logic [15:0] s3, r3, d3;
  logic [2:0] s2, r2, d2;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fb_swap_scheduler #(.NUM_BUF(3), .CNT_W(16)) u_dut3 (
    .clk_clk(clk), .reset_reset_n(rst_n), .wr_req(wr_req), .wr_grant(g3),
    .wr_addr(a3), .wr_idx(i3), .wr_done(wr_done), .wr_abort(wr_abort),
    .vsync(vsync), .rd_valid(v3), .rd_addr(ra3), .shown_cnt(s3),
    .repeat_cnt(r3), .drop_cnt(d3), .proto_err(p3));

  fb_swap_scheduler #(.NUM_BUF(2), .CNT_W(3)) u_dut2 (
    .clk_clk(clk), .reset_reset_n(rst_n), .wr_req(wr_req), .wr_grant(g2),
    .wr_addr(a2), .wr_idx(i2), .wr_done(wr_done), .wr_abort(wr_abort),
    .vsync(vsync), .rd_valid(v2), .rd_addr(ra2), .shown_cnt(s2),
    .repeat_cnt(r2), .drop_cnt(d2), .proto_err(p2));

  // Reference model: which buffer plays each role (-1 = none).
  int nb_of[2]  = '{3, 2};
  int max_of[2] = '{65535, 7};
  int m_wi[2], m_ri[2], m_di[2], m_idx[2], m_shown[2], m_rep[2], m_drop[2];
  bit m_pend[2], m_grant[2], m_rv[2], m_perr[2];
  logic [31:0] m_waddr[2], m_raddr[2];

  function automatic logic [31:0] maddr(input int i);
    logic [31:0] base = 32'h0000_0000;
    logic [31:0] stride = 32'h0020_0000;
    return base + 32'(i) * stride;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_wi[k] = -1; m_ri[k] = -1; m_di[k] = -1; m_idx[k] = 0;
      m_shown[k] = 0; m_rep[k] = 0; m_drop[k] = 0;
      m_pend[k] = 0; m_grant[k] = 0; m_rv[k] = 0; m_perr[k] = 0;
      m_waddr[k] = maddr(0); m_raddr[k] = maddr(0);
    end
  endtask

  task automatic model_step(input bit r, input bit d, input bit a, input bit v);
    for (int k = 0; k < 2; k++) begin
      int pw = m_wi[k];
      int pr = m_ri[k];
      int pd = m_di[k];
      bit writing = (pw >= 0);
      bit gnow = m_grant[k];
      m_grant[k] = 0;
      if ((d || a) && !writing) m_perr[k] = 1;
      if (r && writing && !gnow) m_perr[k] = 1;
      if (v) begin
        if (pr >= 0) begin
          m_di[k] = pr; m_ri[k] = -1; m_raddr[k] = maddr(pr); m_rv[k] = 1;
          if (m_shown[k] < max_of[k]) m_shown[k]++;
        end else if (m_rv[k]) begin
          if (m_rep[k] < max_of[k]) m_rep[k]++;
        end
      end
      if (writing && a) begin
        m_wi[k] = -1;
      end else if (writing && d) begin
        if (pr >= 0 && !v && m_drop[k] < max_of[k]) m_drop[k]++;
        m_ri[k] = pw;
        m_wi[k] = -1;
      end
      if (!writing && (m_pend[k] || r)) begin
        int f = -1;
        for (int i = nb_of[k] - 1; i >= 0; i--)
          if (i != pr && i != pd) f = i;
        if (f >= 0) begin
          m_wi[k] = f; m_grant[k] = 1; m_idx[k] = f; m_waddr[k] = maddr(f);
          m_pend[k] = 0;
        end else begin
          m_pend[k] = 1;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("grant3", 32'(g3), 32'(m_grant[0]));
    chk("idx3", 32'(i3), 32'(m_idx[0]));
    chk("waddr3", a3, m_waddr[0]);
    chk("rvalid3", 32'(v3), 32'(m_rv[0]));
    chk("raddr3", ra3, m_raddr[0]);
    chk("shown3", 32'(s3), 32'(m_shown[0]));
    chk("repeat3", 32'(r3), 32'(m_rep[0]));
    chk("drop3", 32'(d3), 32'(m_drop[0]));
    chk("perr3", 32'(p3), 32'(m_perr[0]));
    chk("grant2", 32'(g2), 32'(m_grant[1]));
    chk("idx2", 32'(i2), 32'(m_idx[1]));
    chk("waddr2", a2, m_waddr[1]);
    chk("rvalid2", 32'(v2), 32'(m_rv[1]));
    chk("raddr2", ra2, m_raddr[1]);
    chk("shown2", 32'(s2), 32'(m_shown[1]));
    chk("repeat2", 32'(r2), 32'(m_rep[1]));
    chk("drop2", 32'(d2), 32'(m_drop[1]));
    chk("perr2", 32'(p2), 32'(m_perr[1]));
  endtask

  task automatic tick(input bit r, input bit d, input bit a, input bit v);
    wr_req = r; wr_done = d; wr_abort = a; vsync = v;
    @(posedge clk);
    model_step(r, d, a, v);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    wr_req = 0; wr_done = 0; wr_abort = 0; vsync = 0;
    rst_n = 0;
    model_reset();
    #2;
    chk("rst_grant3", 32'(g3), 32'd0);
    chk("rst_idx3", 32'(i3), 32'd0);
    chk("rst_waddr3", a3, 32'h0);
    chk("rst_rvalid3", 32'(v3), 32'd0);
    chk("rst_raddr3", ra3, 32'h0);
    chk("rst_cnt3", 32'(s3) | 32'(r3) | 32'(d3), 32'd0);
    chk("rst_perr3", 32'(p3), 32'd0);
    chk("rst_grant2", 32'(g2), 32'd0);
    chk("rst_rvalid2", 32'(v2), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1;
    tick(0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    #1;
    do_reset();

    // first frame through the pipeline
    tick(1, 0, 0, 0);
    chk("t1_grant", 32'(g3), 32'd1);
    chk("t1_idx", 32'(i3), 32'd0);
    chk("t1_waddr", a3, 32'h0);
    tick(0, 0, 0, 0);
    chk("t1_grant_pulse", 32'(g3), 32'd0);
    tick(0, 1, 0, 0);
    tick(0, 0, 0, 1);
    chk("t1_rvalid", 32'(v3), 32'd1);
    chk("t1_raddr", ra3, 32'h0);
    chk("t1_shown", 32'(s3), 32'd1);

    // two commits without vsync: one drop
    do_reset();
    tick(1, 0, 0, 0); tick(0, 0, 0, 0); tick(0, 1, 0, 0);
    tick(1, 0, 0, 0);
    chk("t2_waddr1", a3, 32'h0020_0000);
    tick(0, 0, 0, 0); tick(0, 1, 0, 0);
    chk("t2_drop", 32'(d3), 32'd1);
    tick(0, 0, 0, 1);
    chk("t2_raddr", ra3, 32'h0020_0000);

    // vsync and wr_done together; then done+abort together
    do_reset();
    tick(1, 0, 0, 0); tick(0, 0, 0, 0); tick(0, 1, 0, 0);
    tick(1, 0, 0, 0); tick(0, 0, 0, 0);
    tick(0, 1, 0, 1);
    chk("t3_raddr", ra3, 32'h0);
    chk("t3_drop", 32'(d3), 32'd0);
    tick(0, 0, 0, 1);
    chk("t3_raddr_next", ra3, 32'h0020_0000);
    chk("t3_shown", 32'(s3), 32'd2);
    tick(1, 0, 0, 0);
    chk("t3_regrant_idx", 32'(i3), 32'd0);
    tick(0, 0, 0, 0);
    tick(0, 1, 1, 0);
    tick(0, 0, 0, 1);
    chk("t3_abort_repeat", 32'(r3), 32'd1);
    chk("t3_abort_raddr", ra3, 32'h0020_0000);
    chk("t3_abort_drop", 32'(d3), 32'd0);

    // two-buffer instance starved until vsync frees a buffer
    do_reset();
    tick(1, 0, 0, 0); tick(0, 0, 0, 0); tick(0, 1, 0, 0); tick(0, 0, 0, 1);
    tick(1, 0, 0, 0); tick(0, 0, 0, 0); tick(0, 1, 0, 0);
    tick(1, 0, 0, 0);
    chk("t4_nogrant_a", 32'(g2), 32'd0);
    chk("t4_grant3_idx2", 32'(i3), 32'd2);
    tick(1, 0, 0, 0);
    chk("t4_nogrant_b", 32'(g2), 32'd0);
    tick(1, 0, 0, 1);
    chk("t4_nogrant_vs", 32'(g2), 32'd0);
    chk("t4_raddr2", ra2, 32'h0020_0000);
    tick(1, 0, 0, 0);
    chk("t4_grant2", 32'(g2), 32'd1);
    chk("t4_idx2", 32'(i2), 32'd0);
    tick(0, 0, 0, 0);

    // repeats, protocol error, saturation of the 3-bit counter
    do_reset();
    tick(1, 0, 0, 0); tick(0, 0, 0, 0); tick(0, 1, 0, 0); tick(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 1);
    chk("t5_repeat", 32'(r3), 32'd3);
    tick(0, 1, 0, 0);
    chk("t5_perr", 32'(p3), 32'd1);
    chk("t5_raddr", ra3, 32'h0);
    tick(0, 0, 0, 1);
    chk("t5_repeat_after", 32'(r3), 32'd4);
    for (int i = 0; i < 6; i++) tick(0, 0, 0, 1);
    chk("t5_repeat3", 32'(r3), 32'd10);
    chk("t5_repeat2_sat", 32'(r2), 32'd7);
    chk("t5_perr_sticky", 32'(p3), 32'd1);

    // reset while buffer 2 is being written
    do_reset();
    tick(1, 0, 0, 0); tick(0, 0, 0, 0); tick(0, 1, 0, 0); tick(0, 0, 0, 1);
    tick(1, 0, 0, 0); tick(0, 0, 0, 0); tick(0, 1, 0, 0);
    tick(1, 0, 0, 0);
    chk("t6_idx2", 32'(i3), 32'd2);
    chk("t6_waddr2", a3, 32'h0040_0000);
    tick(0, 0, 0, 0);
    do_reset();
    tick(1, 0, 0, 0);
    chk("t6_regrant", 32'(g3), 32'd1);
    chk("t6_regrant_idx", 32'(i3), 32'd0);
    tick(0, 0, 0, 0);

    // randomized traffic, mostly well-behaved writer, one mid-run reset
    do_reset();
    for (int n = 0; n < 400; n++) begin
      bit r, d, a, v;
      r = 0; d = 0; a = 0;
      if (m_wi[0] < 0) r = m_pend[0] || ($urandom_range(0, 3) == 0);
      else begin
        d = ($urandom_range(0, 3) == 0);
        a = ($urandom_range(0, 9) == 0);
      end
      if ($urandom_range(0, 63) == 0) d = 1;
      if ($urandom_range(0, 63) == 0) r = 1;
      v = ($urandom_range(0, 4) == 0);
      if (n == 200) do_reset();
      else tick(r, d, a, v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
